// File: rtl/mont_mult.sv
// Sequential radix-2 Montgomery multiplier: z = x * y * 2^-BITS mod m.
// Runs once after reset is released (BITS+2 edges), then holds z until the next reset.
`ifndef BITS
`define BITS 32
`endif

module mont_mult #(
   parameter int BITS = `BITS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] x,
   input  logic [BITS-1:0] y,
   input  logic [BITS-1:0] m,
   output logic [BITS-1:0] z
);

   localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ITER  = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [BITS-1:0] xreg;
   logic [BITS-1:0] yreg;
   logic [BITS-1:0] mreg;
   logic [BITS+1:0] acc;
   logic [CW-1:0]   cnt;

   logic [BITS+1:0] t_add;
   logic [BITS+1:0] t_red;
   logic [BITS+1:0] acc_nxt;
   logic [BITS+1:0] acc_sub;
   logic            last_bit;

   // With acc < 2m, acc + y + m < 4m, so BITS+2 bits hold every intermediate exactly.
   always_comb begin
      t_add    = acc + (xreg[cnt] ? {2'b00, yreg} : '0);
      t_red    = t_add[0] ? (t_add + {2'b00, mreg}) : t_add;
      acc_nxt  = t_red >> 1;
      acc_sub  = acc - {2'b00, mreg};
      last_bit = (cnt == CW'(BITS - 1));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    state_nxt = ITER;
         ITER:    state_nxt = last_bit ? FINAL : ITER;
         FINAL:   state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xreg <= '0;
         yreg <= '0;
         mreg <= '0;
         acc  <= '0;
         cnt  <= '0;
         z    <= '0;
      end else begin
         case (state)
            LOAD: begin
               xreg <= x;
               yreg <= y;
               mreg <= m;
               acc  <= '0;
               cnt  <= '0;
            end
            ITER: begin
               acc <= acc_nxt;
               cnt <= cnt + CW'(1);
            end
            FINAL: begin
               z <= (acc >= {2'b00, mreg}) ? acc_sub[BITS-1:0] : acc[BITS-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mont_mult.sv
// Directed bench for mont_mult: latency, golden results, boundary operands,
// mid-operation reset and input changes after the operands are captured.
module tb_mont_mult;

   localparam int W = 32;
   localparam logic [W-1:0] MOD   = 32'd4292870399;
   localparam logic [W-1:0] RMODM = 32'd2096897;

   logic         clk;
   logic         rst;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic [W-1:0] m;
   logic [W-1:0] z;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];

   mont_mult #(.BITS(W)) dut (
      .clk(clk),
      .rst(rst),
      .x  (x),
      .y  (y),
      .m  (m),
      .z  (z)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Golden model: reduce x*y, then multiply by 2^-32 built from repeated halving mod m.
   function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] mm);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      return W'(p % {32'd0, mm});
   endfunction

   function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] mm);
      logic [W:0]   half;
      logic [W-1:0] rinv;
      half = ({1'b0, mm} + 33'd1) >> 1;
      rinv = 32'd1;
      for (int i = 0; i < W; i++) rinv = mulmod(rinv, half[W-1:0], mm);
      return mulmod(mulmod(a, b, mm), rinv, mm);
   endfunction

   // driver tasks
   task automatic start_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                           input logic [W-1:0] mv, input string tag);
      @(negedge clk);
      rst = 1'b1;
      x   = xv;
      y   = yv;
      m   = mv;
      #1;
      check({tag, "_in_reset"}, z, '0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Walks the BITS+2 edges after release; z must be 0 until the last one.
   task automatic run_edges(input string tag, input bit toggle, input int hold);
      logic [W-1:0] want;
      for (int e = 1; e <= W + 2; e++) begin
         @(posedge clk);
         #1;
         if (toggle) begin
            x = $urandom_range(32'hFFFF_FFFF, 0);
            y = $urandom_range(32'hFFFF_FFFF, 0);
            m = $urandom_range(32'hFFFF_FFFF, 0);
         end
         if (e == 1 || e == W + 1) check({tag, "_early_zero"}, z, '0);
      end
      want = exp_q.pop_front();
      check({tag, "_result"}, z, want);
      if (hold > 0) begin
         repeat (hold) begin
            @(posedge clk);
            #1;
            if (toggle) x = $urandom_range(32'hFFFF_FFFF, 0);
         end
         check({tag, "_hold"}, z, want);
      end
   endtask

   task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic [W-1:0] want, input string tag, input bit toggle);
      exp_q.push_back(want);
      start_op(xv, yv, MOD, tag);
      run_edges(tag, toggle, 5);
   endtask

   initial begin
      rst = 1'b1;
      x   = '0;
      y   = '0;
      m   = MOD;
      #5;
      check("por_z", z, '0);

      // full-latency golden run, then a long hold
      exp_q.push_back(golden(32'd2193187897, 32'd2193187897, MOD));
      start_op(32'd2193187897, 32'd2193187897, MOD, "sq");
      run_edges("sq", 1'b0, 120);

      // R mod m acts as the Montgomery identity
      run_op(RMODM, 32'd12345, 32'd12345, "ident_y", 1'b0);
      run_op(32'd12345, RMODM, 32'd12345, "ident_x", 1'b0);
      run_op(RMODM, MOD - 32'd1, MOD - 32'd1, "ident_max", 1'b0);
      run_op(32'd0, 32'd2193187897, 32'd0, "x_zero", 1'b0);
      run_op(32'd2193187897, 32'd0, 32'd0, "y_zero", 1'b0);
      run_op(32'd3, 32'd5, golden(32'd3, 32'd5, MOD), "small", 1'b0);

      // reset in the middle of an operation
      start_op(32'd2193187897, 32'd2193187897, MOD, "mid");
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      x   = RMODM;
      y   = 32'd12345;
      #1;
      check("mid_abort_z", z, '0);
      @(negedge clk);
      check("mid_reset_z", z, '0);
      rst = 1'b0;
      exp_q.push_back(32'd12345);
      run_edges("mid", 1'b0, 0);

      // inputs scrambled after the capture edge must not matter
      run_op(RMODM, 32'd777777, 32'd777777, "toggle", 1'b1);
      run_op(32'd2193187897, 32'd2193187897, golden(32'd2193187897, 32'd2193187897, MOD),
             "toggle_sq", 1'b1);

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mont_mult.md
Name: mont_mult

Overview:
- Sequential radix-2 Montgomery multiplier.
- Computes z = x * y * R^-1 mod m, with R = 2^BITS.
- Core building block of the RSA modular-exponentiation datapath.
- One-shot operation: starts automatically after reset is released, runs to completion, then holds the result until the next reset.

Parameters:
- BITS, 32, operand/modulus width. Taken from the project-wide `BITS define in defines.vh; all ports are sized from it.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- x  input  BITS  multiplicand, unsigned, must satisfy x < m
- y  input  BITS  multiplier, unsigned, must satisfy y < m
- m  input  BITS  modulus, unsigned, must be odd, m > 1
- z  output  BITS  registered result, x*y*2^-BITS mod m, in the range [0, m-1]

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst asserted: immediately clears all state, including z=0, accumulator=0, counter=0, state=LOAD.
- States: LOAD -> ITER -> FINAL -> DONE.
- LOAD:
  - Entered on reset.
  - At the first rising clk edge with rst low:
    - register x, y, m into internal operand registers;
    - clear accumulator A (BITS+2 bits wide);
    - counter=0;
    - go to ITER.
  - After this edge, input changes have no effect until the next reset.
- ITER, one bit per edge, i = counter, LSB first:
  - T = A + (xreg[i] ? yreg : 0)
  - if T is odd, T = T + mreg
  - A = T >> 1
  - counter++
  - After BITS iterations (counter == BITS-1 processed), go to FINAL.
- Width rule:
  - The invariant A < 2m must hold.
  - Intermediate T needs BITS+2 bits; no bit may be truncated.
- FINAL, one edge:
  - z = (A >= m) ? A - m : A
  - go to DONE.
- DONE:
  - z held stable indefinitely; no further computation.
- Latency:
  - z is valid after exactly BITS+2 rising edges following rst deassertion (34 for BITS=32).
  - z reads 0 before that point.
- Reset mid-operation: aborts immediately, z=0, and a fresh operation restarts on release.
- Boundary conditions:
  - x=0 or y=0 gives z=0.
  - x = R mod m gives z = y (and symmetrically for y).
  - An even m, or an operand >= m, gives an unspecified z value, but the FSM still reaches DONE in BITS+2 cycles and never hangs.
- No combinational path from inputs to z.

Test Plan:
- m=4292870399, x=y=2193187897, rst released at 20 ns, 20 ns clock -> z=0 for the first 33 edges after release; at edge 34, z equals golden-model (x*y*modinv(2^32,m)) mod m; z then stays constant for 100+ cycles.
- m=4292870399, x=2096897 (=2^32 mod m), y=12345 -> z=12345.
- m=4292870399, x=2096897, y=4292870398 -> z=4292870398 (exercises the final subtraction and the full-width carry).
- m=4292870399, x=0, y=2193187897 -> z=0.
- Mid-operation reset: assert rst at edge 10, change y to 12345 with x=2096897, release -> z=0 during reset, then z=12345 exactly 34 edges after release.
- Inputs toggled randomly after the LOAD edge -> result unchanged, i.e. still equals the value computed from the operands captured at LOAD.
